// File: rtl/posit_operand_sequencer_if.sv
// Handshake and field bus for posit_operand_sequencer.
//   in_*   : operand-pair intake (valid/ready, A and B posits)
//   ext_*  : shared combinational field extractor (ext_in out, decoded fields back)
//   out_*  : decoded-pair delivery (valid/ready) plus captured fields and flags
// slave  = sequencer view, master = environment view.
interface posit_operand_sequencer_if #(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = $clog2(N),
  parameter int CW = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         in_a;
  logic [N-1:0]         in_b;

  logic [N-1:0]         ext_in;
  logic                 ext_sign;
  logic signed [RS+1:0] ext_regime;
  logic [ES-1:0]        ext_exponent;
  logic [N-1:0]         ext_mantissa;
  logic                 ext_inf;
  logic                 ext_zero;

  logic                 out_valid;
  logic                 out_ready;
  logic                 a_sign,     b_sign;
  logic signed [RS+1:0] a_regime,   b_regime;
  logic [ES-1:0]        a_exponent, b_exponent;
  logic [N-1:0]         a_mantissa, b_mantissa;
  logic                 res_nar;
  logic                 res_zero;
  logic [CW-1:0]        pair_count;

  modport slave (
    input  in_valid, in_a, in_b,
    input  ext_sign, ext_regime, ext_exponent, ext_mantissa, ext_inf, ext_zero,
    input  out_ready,
    output in_ready, ext_in, out_valid,
    output a_sign, a_regime, a_exponent, a_mantissa,
    output b_sign, b_regime, b_exponent, b_mantissa,
    output res_nar, res_zero, pair_count
  );

  modport master (
    output in_valid, in_a, in_b,
    output ext_sign, ext_regime, ext_exponent, ext_mantissa, ext_inf, ext_zero,
    output out_ready,
    input  in_ready, ext_in, out_valid,
    input  a_sign, a_regime, a_exponent, a_mantissa,
    input  b_sign, b_regime, b_exponent, b_mantissa,
    input  res_nar, res_zero, pair_count
  );
endinterface

// File: rtl/posit_operand_sequencer.sv
// Shares one combinational posit field extractor between the two operands of
// a posit multiply: A is decoded in DEC_A, B in DEC_B (skipped when A is NaR),
// and the captured fields are offered as one pair until the consumer accepts.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : posit_operand_sequencer_if.slave (intake, extractor, output)
module posit_operand_sequencer #(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = $clog2(N),
  parameter int CW = 16
) (
  input  logic clk,
  input  logic rst_n,
  posit_operand_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DEC_A, DEC_B, OUT} state_t;

  state_t               r_state, w_next;
  logic [N-1:0]         r_a, r_b;
  logic                 r_a_nar, r_a_zero;
  logic                 r_out_valid;
  logic                 r_a_sign, r_b_sign;
  logic signed [RS+1:0] r_a_regime, r_b_regime;
  logic [ES-1:0]        r_a_exp, r_b_exp;
  logic [N-1:0]         r_a_mant, r_b_mant;
  logic                 r_res_nar, r_res_zero;
  logic [CW-1:0]        r_pair_count;
  logic [N-1:0]         w_ext_in;
  logic                 w_accept;
  logic                 w_b_nar;

  // in_ready depends only on state and reset, never on in_valid.
  assign bus.in_ready = (r_state == IDLE) & rst_n;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_b_nar      = r_a_nar | bus.ext_inf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = DEC_A;
      DEC_A:   w_next = bus.ext_inf ? OUT : DEC_B;
      DEC_B:   w_next = OUT;
      OUT:     if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Extractor input is held at zero outside decode cycles to avoid toggling.
  always_comb begin
    w_ext_in = '0;
    case (r_state)
      DEC_A:   w_ext_in = r_a;
      DEC_B:   w_ext_in = r_b;
      default: w_ext_in = '0;
    endcase
  end
  assign bus.ext_in = w_ext_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_a_nar      <= 1'b0;
      r_a_zero     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_a_sign     <= 1'b0;
      r_a_regime   <= '0;
      r_a_exp      <= '0;
      r_a_mant     <= '0;
      r_b_sign     <= 1'b0;
      r_b_regime   <= '0;
      r_b_exp      <= '0;
      r_b_mant     <= '0;
      r_res_nar    <= 1'b0;
      r_res_zero   <= 1'b0;
      r_pair_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a <= bus.in_a;
            r_b <= bus.in_b;
          end
        end
        DEC_A: begin
          r_a_sign   <= bus.ext_sign;
          r_a_regime <= bus.ext_regime;
          r_a_exp    <= bus.ext_exponent;
          r_a_mant   <= bus.ext_mantissa;
          r_a_nar    <= bus.ext_inf;
          r_a_zero   <= bus.ext_zero;
          if (bus.ext_inf) begin
            // NaR absorbs anything: B is never decoded, its fields read as 0.
            r_b_sign    <= 1'b0;
            r_b_regime  <= '0;
            r_b_exp     <= '0;
            r_b_mant    <= '0;
            r_res_nar   <= 1'b1;
            r_res_zero  <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        DEC_B: begin
          r_b_sign    <= bus.ext_sign;
          r_b_regime  <= bus.ext_regime;
          r_b_exp     <= bus.ext_exponent;
          r_b_mant    <= bus.ext_mantissa;
          r_res_nar   <= w_b_nar;
          // zero * NaR is NaR, so NaR masks the zero flag.
          r_res_zero  <= (r_a_zero | bus.ext_zero) & ~w_b_nar;
          r_out_valid <= 1'b1;
        end
        OUT: begin
          if (bus.out_ready) begin
            r_out_valid  <= 1'b0;
            r_pair_count <= r_pair_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.a_sign     = r_a_sign;
  assign bus.a_regime   = r_a_regime;
  assign bus.a_exponent = r_a_exp;
  assign bus.a_mantissa = r_a_mant;
  assign bus.b_sign     = r_b_sign;
  assign bus.b_regime   = r_b_regime;
  assign bus.b_exponent = r_b_exp;
  assign bus.b_mantissa = r_b_mant;
  assign bus.res_nar    = r_res_nar;
  assign bus.res_zero   = r_res_zero;
  assign bus.pair_count = r_pair_count;

endmodule

// File: tb/tb_posit_operand_sequencer.sv
// Randomized self-checking bench for posit_operand_sequencer (N=8, ES=3,
// CW=4 so the pair counter wraps quickly). A behavioural posit decoder serves
// both as the extractor in the loop and as the source of expected fields.
module tb_posit_operand_sequencer;
  localparam int N  = 8;
  localparam int ES = 3;
  localparam int RS = $clog2(N);
  localparam int CW = 4;

  typedef struct packed {
    logic                 s;
    logic signed [RS+1:0] k;
    logic [ES-1:0]        e;
    logic [N-1:0]         m;
    logic                 inf;
    logic                 zero;
  } dec_t;

  logic gclk = 1'b0;
  logic grst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  always #5 gclk = ~gclk;

  posit_operand_sequencer_if #(.N(N), .ES(ES), .RS(RS), .CW(CW)) bus ();

  posit_operand_sequencer #(.N(N), .ES(ES), .RS(RS), .CW(CW)) dut (
    .clk  (gclk),
    .rst_n(grst_n),
    .bus  (bus)
  );

  // Posit decode from first principles: sign, regime run length, then ES
  // exponent bits and fraction, missing bits read as zero.
  function automatic dec_t decode(input logic [N-1:0] p);
    dec_t         d;
    logic [N-1:0] v;
    logic         r0;
    int           pos, run;
    d = '0;
    if (p == '0) d.zero = 1'b1;
    else if (p == {1'b1, {(N-1){1'b0}}}) d.inf = 1'b1;
    else begin
      d.s = p[N-1];
      v   = d.s ? (~p + 1'b1) : p;
      r0  = v[N-2];
      pos = N-2;
      run = 0;
      while (pos >= 0 && v[pos] == r0) begin run++; pos--; end
      pos--;
      d.k = (RS+2)'(r0 ? run - 1 : -run);
      for (int i = ES-1; i >= 0; i--) begin
        d.e[i] = (pos >= 0) ? v[pos] : 1'b0;
        pos--;
      end
      d.m[N-1] = 1'b1;
      for (int j = N-2; j >= 0; j--) begin
        d.m[j] = (pos >= 0) ? v[pos] : 1'b0;
        pos--;
      end
    end
    return d;
  endfunction

  // Extractor in the loop.
  always_comb begin
    dec_t x;
    x = decode(bus.ext_in);
    bus.ext_sign     = x.s;
    bus.ext_regime   = x.k;
    bus.ext_exponent = x.e;
    bus.ext_mantissa = x.m;
    bus.ext_inf      = x.inf;
    bus.ext_zero     = x.zero;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] snap();
    return {27'd0, bus.out_valid, bus.a_sign, bus.a_regime, bus.a_exponent, bus.a_mantissa,
            bus.b_sign, bus.b_regime, bus.b_exponent, bus.b_mantissa,
            bus.res_nar, bus.res_zero, bus.pair_count};
  endfunction

  // Called at a negedge with the sequencer idle; returns at a negedge, idle.
  // hold > 0 keeps out_ready low that many cycles with (na, nb) pending.
  task automatic run_pair(input logic [N-1:0] a, input logic [N-1:0] b, input int hold,
                          input logic [N-1:0] na, input logic [N-1:0] nb);
    dec_t        da, db;
    logic        nar, zer;
    logic [63:0] s0;
    da = decode(a);
    db = decode(b);
    nar = da.inf | db.inf;
    zer = (da.zero | db.zero) & ~nar;
    if (da.inf) db = '0;
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    chk("in_ready_idle", bus.in_ready, 1);
    @(negedge gclk);                    // acceptance edge (1st)
    bus.in_valid = 1'b0;
    chk("ext_a", bus.ext_in, a);
    chk("ov_dec_a", bus.out_valid, 0);
    if (!da.inf) begin
      @(negedge gclk);                  // 2nd edge
      chk("ext_b", bus.ext_in, b);
      chk("ov_dec_b", bus.out_valid, 0);
    end
    @(negedge gclk);                    // 3rd edge (2nd on NaR-A)
    chk("lat_ov", bus.out_valid, 1);
    chk("ext_out", bus.ext_in, 0);
    chk("in_ready_out", bus.in_ready, 0);
    chk("a_sign", bus.a_sign, da.s);
    chk("a_regime", bus.a_regime, da.k);
    chk("a_exp", bus.a_exponent, da.e);
    chk("a_mant", bus.a_mantissa, da.m);
    chk("b_sign", bus.b_sign, db.s);
    chk("b_regime", bus.b_regime, db.k);
    chk("b_exp", bus.b_exponent, db.e);
    chk("b_mant", bus.b_mantissa, db.m);
    chk("res_nar", bus.res_nar, nar);
    chk("res_zero", bus.res_zero, zer);
    s0 = snap();
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = na;
      bus.in_b     = nb;
      @(negedge gclk);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_stable", snap(), s0);
    end
    bus.out_ready = 1'b1;
    @(negedge gclk);                    // handshake edge
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    chk("ov_drop", bus.out_valid, 0);
    chk("pair_count", bus.pair_count, exp_cnt);
    chk("in_ready_back", bus.in_ready, 1);
  endtask

  function automatic logic [N-1:0] rnd_posit();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return '0;
    if (sel == 1) return {1'b1, {(N-1){1'b0}}};
    return N'($urandom);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] pa, pb;
    grst_n        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge gclk);
    chk("rst_in_ready", bus.in_ready, 0);
    grst_n = 1'b1;
    @(negedge gclk);
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_out_valid", bus.out_valid, 0);
    chk("idle_ext_in", bus.ext_in, 0);
    chk("idle_count", bus.pair_count, 0);
    chk("idle_snap", snap(), 64'd0);

    // Directed corners.
    run_pair(8'h40, 8'h40, 0, 8'h00, 8'h00);
    chk("one_mant", bus.a_mantissa, 8'h80);
    chk("one_regime", bus.a_regime, 0);
    run_pair(8'h80, 8'h40, 0, 8'h00, 8'h00);
    chk("nar_b_zeroed", {bus.b_sign, bus.b_regime, bus.b_exponent, bus.b_mantissa}, 0);
    run_pair(8'h00, 8'h80, 0, 8'h00, 8'h00);
    run_pair(8'h00, 8'h40, 0, 8'h00, 8'h00);

    // Backpressure with a pending pair, accepted right after the handshake.
    pa = rnd_posit();
    pb = rnd_posit();
    run_pair(8'h3c, 8'hc5, 5, pa, pb);
    run_pair(pa, pb, 0, 8'h00, 8'h00);

    // Reset mid-decode: pair is dropped, everything clears.
    bus.in_valid = 1'b1;
    bus.in_a     = 8'h52;
    bus.in_b     = 8'h61;
    @(negedge gclk);
    bus.in_valid = 1'b0;
    @(negedge gclk);                    // now in DEC_B
    chk("pre_rst_ext_b", bus.ext_in, 8'h61);
    grst_n = 1'b0;
    #1;
    chk("mid_rst_snap", snap(), 64'd0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_ext", bus.ext_in, 0);
    exp_cnt = 0;
    @(negedge gclk);
    grst_n = 1'b1;
    repeat (3) begin
      @(negedge gclk);
      chk("post_rst_ov", bus.out_valid, 0);
      chk("post_rst_ready", bus.in_ready, 1);
    end

    // 2^CW random pairs back to back: counter wraps to 0.
    for (int i = 0; i < (1 << CW); i++) begin
      pa = rnd_posit();
      pb = rnd_posit();
      run_pair(pa, pb, (i % 5 == 3) ? int'($urandom_range(1, 3)) : 0, pa, pb);
    end
    chk("wrap_count", bus.pair_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
